// File: rtl/keypad_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | keypad_scan: 4x4 matrix keypad scanner with frame debounce and events  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module keypad_scan #(
  parameter int PERIOD   = 12500,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  col,
  input  logic [3:0]  row,
  output logic [15:0] key_down,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int             CW           = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0]  C_LAST       = CW'(PERIOD - 1);
  localparam logic [4:0]     C_STABLE_MAX = 5'(DEBOUNCE - 1);

  logic [CW-1:0] r_count;
  logic [1:0]    r_idx;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [15:0]   r_shadow;
  logic [15:0]   r_cand;
  logic [3:0]    r_stable;

  logic          w_sample;
  logic          w_frame_end;
  logic [3:0]    w_rows;
  logic [15:0]   w_frame;
  logic [4:0]    w_stable_inc;
  logic          w_settled;
  logic [15:0]   w_new;
  logic [3:0]    w_low_code;

  assign w_rows       = ~r_sync2;
  assign w_sample     = (r_count == C_LAST);
  assign w_frame_end  = w_sample && (r_idx == 2'd3);
  // The last column is still in the synchronizer, so splice it in directly.
  assign w_frame      = {w_rows, r_shadow[11:0]};
  assign w_stable_inc = {1'b0, r_stable} + 5'd1;
  assign w_settled    = (w_stable_inc >= C_STABLE_MAX);
  assign w_new        = r_cand & ~key_down;

  always_comb begin
    w_low_code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_new[i]) w_low_code = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= 4'b1110;
      r_count   <= '0;
      r_idx     <= 2'd0;
      r_sync1   <= 4'b1111;
      r_sync2   <= 4'b1111;
      r_shadow  <= '0;
      r_cand    <= '0;
      r_stable  <= '0;
      key_down  <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      r_sync1   <= row;
      r_sync2   <= r_sync1;
      col       <= ~(4'b0001 << r_idx);
      key_valid <= 1'b0;

      if (w_sample) begin
        r_count                   <= '0;
        r_idx                     <= r_idx + 2'd1;
        r_shadow[{r_idx, 2'b00} +: 4] <= w_rows;
      end else begin
        r_count <= r_count + 1'b1;
      end

      if (w_frame_end) begin
        if (w_frame != r_cand) begin
          r_cand   <= w_frame;
          r_stable <= '0;
        end else begin
          r_stable <= w_settled ? C_STABLE_MAX[3:0] : w_stable_inc[3:0];
          if (w_settled) begin
            key_down <= r_cand;
            if (|w_new) begin
              key_valid <= 1'b1;
              key_code  <= w_low_code;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_keypad_scan: self-checking bench for keypad_scan (PERIOD=4, DEB=3)  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_keypad_scan;

  localparam int PERIOD   = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 4 * PERIOD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_down;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] keys = 16'h0000;

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to a low-driven column.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
  end

  keypad_scan #(.PERIOD(PERIOD), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row),
    .key_down(key_down), .key_valid(key_valid), .key_code(key_code)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;

  // Frame-level reference: run length of identical frames.
  logic [15:0] m_cand, m_kd;
  int          m_run;
  logic        m_valid;
  logic [3:0]  m_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [15:0] v);
    int k = 0;
    while (k < 15 && !v[k]) k++;
    return 4'(k);
  endfunction

  task automatic model_frame(input logic [15:0] f);
    logic [15:0] fresh;
    if (f != m_cand) begin
      m_cand = f;
      m_run  = 1;
    end else begin
      m_run++;
      if (m_run >= DEBOUNCE) begin
        fresh = m_cand & ~m_kd;
        if (fresh != 0) begin
          m_valid = 1'b1;
          m_code  = lowest(fresh);
        end
        m_kd = m_cand;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] ecol;
    @(posedge clk);
    #1;
    n++;
    m_valid = 1'b0;
    if (n % FRAME == 0) model_frame(keys);
    ecol = ~(4'b0001 << (((n - 1) / PERIOD) % 4));
    check("col", col, ecol);
    check("key_down", key_down, m_kd);
    check("key_valid", key_valid, m_valid);
    check("key_code", key_code, m_code);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_col", col, 4'b1110);
    check("rst_key_down", key_down, 16'h0000);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_code", key_code, 4'd0);
    m_cand  = '0;
    m_run   = 1;
    m_kd    = '0;
    m_code  = '0;
    m_valid = 1'b0;
    n       = 0;
    reset   = 1'b0;
  endtask

  typedef struct {
    logic [15:0] keys;
    int          reps;
    logic [15:0] kd;
    logic        pulse;
    logic [3:0]  code;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [15:0] kd_prev;
    logic [15:0] k;
    int          hold;

    tbl[0]  = '{16'h0000, 3,  16'h0000, 1'b0, 4'd0};   // idle
    tbl[1]  = '{16'h0040, 2,  16'h0000, 1'b0, 4'd0};   // hold key 6
    tbl[2]  = '{16'h0040, 1,  16'h0040, 1'b1, 4'd6};
    tbl[3]  = '{16'h0040, 10, 16'h0040, 1'b0, 4'd0};
    tbl[4]  = '{16'h0000, 3,  16'h0000, 1'b0, 4'd0};   // release
    tbl[5]  = '{16'h0040, 1,  16'h0000, 1'b0, 4'd0};   // bounce
    tbl[6]  = '{16'h0000, 1,  16'h0000, 1'b0, 4'd0};
    tbl[7]  = '{16'h0040, 1,  16'h0000, 1'b0, 4'd0};
    tbl[8]  = '{16'h0000, 1,  16'h0000, 1'b0, 4'd0};
    tbl[9]  = '{16'h0040, 1,  16'h0000, 1'b0, 4'd0};
    tbl[10] = '{16'h0000, 1,  16'h0000, 1'b0, 4'd0};
    tbl[11] = '{16'h0040, 3,  16'h0040, 1'b1, 4'd6};   // steady after bounce
    tbl[12] = '{16'h0000, 3,  16'h0000, 1'b0, 4'd0};
    tbl[13] = '{16'h0208, 3,  16'h0208, 1'b1, 4'd3};   // keys 3 and 9
    tbl[14] = '{16'h1208, 3,  16'h1208, 1'b1, 4'd12};  // add key 12
    tbl[15] = '{16'h1208, 2,  16'h1208, 1'b0, 4'd0};
    tbl[16] = '{16'h0000, 3,  16'h0000, 1'b0, 4'd0};

    keys = 16'h0000;
    do_reset();

    kd_prev = 16'h0000;
    for (int e = 0; e < 17; e++) begin
      keys = tbl[e].keys;
      for (int f = 0; f < tbl[e].reps; f++) begin
        repeat (FRAME) tick();
        check("tbl_key_down", key_down, (f == tbl[e].reps - 1) ? tbl[e].kd : kd_prev);
        check("tbl_key_valid", key_valid, (f == tbl[e].reps - 1) ? tbl[e].pulse : 1'b0);
        if (f == tbl[e].reps - 1 && tbl[e].pulse)
          check("tbl_key_code", key_code, tbl[e].code);
      end
      kd_prev = tbl[e].kd;
    end

    // Reset in the middle of a debounce restarts the count from scratch.
    keys = 16'h0020;
    repeat (2 * FRAME) tick();
    do_reset();
    repeat (2 * FRAME) tick();
    check("rst_seq_no_early", key_down, 16'h0000);
    repeat (FRAME) tick();
    check("rst_seq_valid", key_valid, 1'b1);
    check("rst_seq_code", key_code, 4'd5);
    check("rst_seq_kd", key_down, 16'h0020);
    tick();
    check("rst_seq_single", key_valid, 1'b0);

    // Randomized frames with occasional mid-frame resets.
    for (int g = 0; g < 60; g++) begin
      if ($urandom_range(0, 3) == 0) k = 16'h0000;
      else k = 16'($urandom) & 16'($urandom) & 16'($urandom);
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        int j;
        keys = k;
        j = ($urandom_range(0, 9) == 0) ? $urandom_range(0, FRAME - 1) : -1;
        for (int i = 0; i < FRAME; i++) begin
          if (i == j) begin
            do_reset();
            break;
          end
          tick();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
